// File: rtl/tanh_bwd_pkg.sv
// tanh_bwd_pkg: shared constants and the rounding shift helper for the tanh backward unit.
// Default scaling is Q8.8; ONE_Q is fixed-point 1.0 at that scaling.
// rshift_round adds half an LSB and shifts arithmetically (round half toward +inf).
package tanh_bwd_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;
  localparam int ONE_Q     = 1 << DEF_FRAC;

  function automatic logic signed [63:0] rshift_round(input logic signed [63:0] value,
                                                      input int                 frac);
    logic signed [63:0] half;
    half = 64'sd1 <<< (frac - 1);
    return (value + half) >>> frac;
  endfunction

endpackage

// File: rtl/tanh_bwd_lane.sv
// tanh_bwd_lane: per-lane datapath, purely combinational.
// Stage-1 half: d = 1.0 - round(y^2), clamped at 0. Stage-2 half: round(grad * d).
// Optional TANH_BWD_STATS_EN exposes the clamp flag for the statistics counter.
module tanh_bwd_lane
  import tanh_bwd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [WIDTH-1:0] grad_i,
  input  logic        [WIDTH:0]   d_i,
  output logic        [WIDTH:0]   d_o,
  output logic signed [WIDTH-1:0] grad_in_o
`ifdef TANH_BWD_STATS_EN
  ,
  output logic                    clamp_o
`endif
);

  // Package constant when running at the default scaling, otherwise derived from FRAC.
  localparam logic signed [63:0] ONE_L = (FRAC == DEF_FRAC) ? 64'(ONE_Q) : (64'sd1 <<< FRAC);

  logic signed [63:0] y_ext;
  logic signed [63:0] ysq;
  logic signed [63:0] d_raw;
  logic               d_neg;
  logic signed [63:0] grad_ext;
  logic signed [63:0] d_ext;
  logic signed [63:0] res;

  // Derivative term 1 - y^2; only an out-of-range y (|y| > 1.0) can drive it negative.
  always_comb begin
    y_ext = 64'(y_i);
    ysq   = rshift_round(y_ext * y_ext, FRAC);
    d_raw = ONE_L - ysq;
    d_neg = (d_raw < 0);
    d_o   = d_neg ? '0 : d_raw[WIDTH:0];
  end

`ifdef TANH_BWD_STATS_EN
  assign clamp_o = d_neg;
`endif

  // Gradient scaling; 0 <= d <= 1.0 guarantees the product fits back into WIDTH bits.
  always_comb begin
    grad_ext  = 64'(grad_i);
    d_ext     = {{(63 - WIDTH){1'b0}}, d_i};
    res       = rshift_round(grad_ext * d_ext, FRAC);
    grad_in_o = res[WIDTH-1:0];
  end

  // The truncation above must never lose significant bits.
  always_comb begin
    assert (res == 64'(grad_in_o));
  end

endmodule

// File: rtl/tanh_bwd.sv
// tanh_bwd: grad_in = grad_out * (1 - y^2) per lane, DIM lanes per beat, Q(WIDTH-FRAC).FRAC.
// Latency 2 cycles (input register stage + output register stage), one beat per cycle.
// Backpressure: in_ready = stage 1 can advance; combinational from out_ready. Macro TANH_BWD_STATS_EN adds stat_clamp_cnt.
module tanh_bwd
  import tanh_bwd_pkg::*;
#(
  parameter int DIM   = 1,
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] in_y,
  input  logic [DIM*WIDTH-1:0] in_grad,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*WIDTH-1:0] out_grad,
  output logic                 out_last
`ifdef TANH_BWD_STATS_EN
  ,
  output logic [31:0]          stat_clamp_cnt
`endif
);

  logic                      s1_valid_q;
  logic [DIM-1:0][WIDTH:0]   s1_d_q;
  logic [DIM-1:0][WIDTH:0]   d_d;
  logic [DIM*WIDTH-1:0]      s1_grad_q;
  logic                      s1_last_q;
  logic                      out_valid_q;
  logic [DIM*WIDTH-1:0]      out_grad_q;
  logic [DIM*WIDTH-1:0]      grad_in_d;
  logic                      out_last_q;
  logic                      s1_adv;
  logic                      s2_adv;
  logic                      in_acc;

  assign s2_adv    = !out_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign in_acc    = in_valid && s1_adv;
  assign out_valid = out_valid_q;
  assign out_grad  = out_grad_q;
  assign out_last  = out_last_q;

`ifdef TANH_BWD_STATS_EN
  logic [DIM-1:0] clamp_d;
`endif

  for (genvar j = 0; j < DIM; j++) begin : g_lane
    tanh_bwd_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_lane (
      .y_i       (in_y[j*WIDTH +: WIDTH]),
      .grad_i    (s1_grad_q[j*WIDTH +: WIDTH]),
      .d_i       (s1_d_q[j]),
      .d_o       (d_d[j]),
      .grad_in_o (grad_in_d[j*WIDTH +: WIDTH])
`ifdef TANH_BWD_STATS_EN
      ,
      .clamp_o   (clamp_d[j])
`endif
    );
  end

  // Stage 1: capture d, grad and last whenever a beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_d_q     <= '0;
      s1_grad_q  <= '0;
      s1_last_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_d_q    <= d_d;
        s1_grad_q <= in_grad;
        s1_last_q <= in_last;
      end
    end
  end

  // Stage 2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_grad_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_grad_q <= grad_in_d;
        out_last_q <= s1_last_q;
      end
    end
  end

`ifdef TANH_BWD_STATS_EN
  logic [31:0] stat_q;
  logic [32:0] stat_d;

  // Add this beat's clamped-lane count; one spare bit flags overflow.
  always_comb begin
    stat_d = {1'b0, stat_q};
    for (int j = 0; j < DIM; j++) begin
      if (clamp_d[j]) stat_d = stat_d + 33'd1;
    end
  end

  // Saturating clamp counter, updated only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (in_acc) begin
      stat_q <= stat_d[32] ? 32'hFFFF_FFFF : stat_d[31:0];
    end
  end

  assign stat_clamp_cnt = stat_q;
`endif

endmodule

// File: tb/tb_tanh_bwd.sv
// Scoreboard bench for tanh_bwd with DIM=4 lanes of Q8.8.
// Stimulus pushes hand-computed expectations on accept; a monitor pops on each output transfer.
module tb_tanh_bwd;

  typedef struct packed {
    logic [63:0] grad;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_y;
  logic [63:0] in_grad;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_grad;
  logic        out_last;
`ifdef TANH_BWD_STATS_EN
  logic [31:0] stat_clamp_cnt;
`endif

  // Hand-computed lane vectors: y, grad, expected grad_in, clamp flag.
  logic [15:0] vy [16] = '{16'h0000, 16'h0080, 16'h0080, 16'h0100, 16'h8000, 16'h0040, 16'h00C0, 16'hFF80,
                           16'h0001, 16'h0010, 16'h00B5, 16'hFF00, 16'h0101, 16'h0080, 16'h0000, 16'h0020};
  logic [15:0] vg [16] = '{16'h0100, 16'h0100, 16'hFF00, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h0200, 16'h0003,
                           16'hFFFF, 16'h0101, 16'h1000, 16'h1234, 16'h0100, 16'h8000, 16'h8000, 16'h0005};
  logic [15:0] ve [16] = '{16'h0100, 16'h00C0, 16'hFF40, 16'h0000, 16'h0000, 16'h00F0, 16'h00E0, 16'h0002,
                           16'hFFFF, 16'h0100, 16'h0800, 16'h0000, 16'h0000, 16'hA000, 16'h8000, 16'h0005};
  logic        vc [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  exp_t sb_q[$];
  int   xfer_cyc_q[$];
  int   acc_cyc_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  int   acc_cnt   = 0;
  int   exp_clamp = 0;
  exp_t mon_e;

  tanh_bwd #(
    .DIM   (4),
    .WIDTH (16),
    .FRAC  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_grad   (in_grad),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grad  (out_grad),
    .out_last  (out_last)
`ifdef TANH_BWD_STATS_EN
    ,
    .stat_clamp_cnt (stat_clamp_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Present one beat built from vectors base..base+3 and wait (bounded) for acceptance.
  task automatic send_beat(input int base, input logic last);
    exp_t e;
    logic got;
    int   idx;
    got = 1'b0;
    in_valid = 1'b1;
    in_last  = last;
    e.last   = last;
    for (int j = 0; j < 4; j++) begin
      idx = (base + j) % 16;
      in_y[j*16 +: 16]    = vy[idx];
      in_grad[j*16 +: 16] = vg[idx];
      e.grad[j*16 +: 16]  = ve[idx];
    end
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (got) begin
      sb_q.push_back(e);
      acc_cyc_q.push_back(cyc);
      acc_cnt++;
      for (int j = 0; j < 4; j++) if (vc[(base + j) % 16]) exp_clamp++;
    end else begin
      chk("accept_timeout", 64'd0, 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb_q.size() != 0; n++) @(negedge clk);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xfer_cyc_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_grad", out_grad, mon_e.grad);
        chk("out_last", 64'(out_last), 64'(mon_e.last));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc0;
    int stale;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_y      = '0;
    in_grad   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_grad", out_grad, 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat: out_valid low one cycle after accept, high two cycles after.
    send_beat(0, 1'b0);
    @(negedge clk);
    chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    drain();

    // Continuous stream: one accept and one output per cycle.
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) send_beat(k * 4, k == 7);
    drain();
    chk("stream_accept_span", 64'(acc_cyc_q[$] - acc_cyc_q[$-7]), 64'd7);
    chk("stream_out_span", 64'(xfer_cyc_q[$] - xfer_cyc_q[$-7]), 64'd7);

    // Backpressure: out_ready low for 4 cycles lets exactly 2 beats in.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        for (int k = 0; k < 8; k++) send_beat(k * 4 + 1, k == 7);
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_accepts", 64'(acc_cnt - acc0), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
`ifdef TANH_BWD_STATS_EN
    chk("clamp_cnt", 64'(stat_clamp_cnt), 64'(exp_clamp));
`endif

    // Reset with two beats in flight: everything is dropped.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_beat(0, 1'b0);
    send_beat(4, 1'b0);
    #2;
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    sb_q.delete();
    exp_clamp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_beat", 64'(stale), 64'd0);
`ifdef TANH_BWD_STATS_EN
    chk("clamp_cnt_rst", 64'(stat_clamp_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    send_beat(4, 1'b1);
    drain();
`ifdef TANH_BWD_STATS_EN
    chk("clamp_cnt_after", 64'(stat_clamp_cnt), 64'(exp_clamp));
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
